// File: rtl/const_div113_seq.sv
// Digit-serial unsigned divide of a DATA_W-bit dividend by the constant DIVISOR, one DIGIT_W digit per cycle, MSB first.
// Build macro CONST_DIV_REM_OUT_EN exposes the final remainder on out_remainder; otherwise it is tied to 0.
module const_div113_seq #(
  parameter int DIVISOR = 113,
  parameter int DATA_W  = 60,
  parameter int DIGIT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dividend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [6:0]        out_remainder,
  output logic              busy
);

  localparam int NDIG  = DATA_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   div_q, div_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [6:0]          rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  qd;
  logic [6:0]          r_next;

  // One digit step as a restoring shift-subtract chain; acc stays below DIVISOR between bits.
  always_comb begin
    logic [7:0] acc;
    acc = {1'b0, rem_q};
    qd  = '0;
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      acc = {acc[6:0], div_q[DATA_W-DIGIT_W+i]};
      if (acc >= 8'(DIVISOR)) begin
        acc   = acc - 8'(DIVISOR);
        qd[i] = 1'b1;
      end
    end
    r_next = acc[6:0];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d   = in_dividend;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        div_d = div_q << DIGIT_W;
        quo_d = {quo_q[DATA_W-DIGIT_W-1:0], qd};
        rem_d = r_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q == RUN);
  assign out_quotient = quo_q;

`ifdef CONST_DIV_REM_OUT_EN
  assign out_remainder = rem_q;
`else
  assign out_remainder = 7'd0;
`endif

endmodule

// File: tb/tb_const_div113_seq.sv
// Bench for const_div113_seq: directed table, backpressure and mid-run reset sequences, then random dividends vs / and % by 113.
module tb_const_div113_seq;

`ifdef CONST_DIV_REM_OUT_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_dividend;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_quotient;
  logic [6:0]  out_remainder;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  const_div113_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .busy         (busy)
  );

  typedef struct {
    logic [59:0] a;
    logic [59:0] q;
    logic [6:0]  r;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected remainder as seen on the port for this build.
  function automatic logic [6:0] port_rem(input logic [6:0] r);
    return REM_EN ? r : 7'd0;
  endfunction

  // One full transaction: optional idle gap, accept, latency check, result check, hold with out_ready low, handshake.
  task automatic do_div(input logic [59:0] a, input logic [59:0] q_exp, input logic [6:0] r_raw,
                        input int pre_gap, input int hold);
    int          cyc;
    logic [6:0]  r_exp;
    r_exp = port_rem(r_raw);
    repeat (pre_gap) @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = a;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid    = 1'b0;
    in_dividend = 60'({$urandom, $urandom});
    chk("run_flags", 128'({busy, in_ready, out_valid}), 128'(3'b100));
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      in_valid = cyc[0];
    end
    in_valid = 1'b0;
    chk("latency", 128'(cyc), 128'(10));
    chk("quotient", 128'(out_quotient), 128'(q_exp));
    chk("remainder", 128'(out_remainder), 128'(r_exp));
    for (int h = 0; h < hold; h++) begin
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_dividend = 60'({$urandom, $urandom});
      @(negedge clk);
      chk("hold", 128'({out_valid, in_ready, busy, out_quotient, out_remainder}),
          128'({3'b100, q_exp, r_exp}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handshake_idle", 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [59:0] a;
    int          pulses;

    tbl[0] = '{60'd0,                   60'd0,                 7'd0};
    tbl[1] = '{60'd112,                 60'd0,                 7'd112};
    tbl[2] = '{60'd113,                 60'd1,                 7'd0};
    tbl[3] = '{60'd12769,               60'd113,               7'd0};
    tbl[4] = '{60'd1152921504606846975, 60'd10202845173511920, 7'd15};
    tbl[5] = '{60'd1000,                60'd8,                 7'd96};

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_dividend = '0;
    repeat (2) @(negedge clk);
    chk("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset_data", 128'({out_quotient, out_remainder}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_div(tbl[i].a, tbl[i].q, tbl[i].r, 0, 0);
    end

    // Backpressure for 5 cycles, then a back-to-back second dividend.
    do_div(60'd987654321012345, 60'd987654321012345 / 60'd113, 7'(60'd987654321012345 % 60'd113), 0, 5);
    do_div(60'd55555555555, 60'd55555555555 / 60'd113, 7'(60'd55555555555 % 60'd113), 0, 0);

    // Reset pulse while digit 4 is being processed.
    in_valid    = 1'b1;
    in_dividend = 60'h0ABC_DEF0_1234_567;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy", 128'({busy, out_valid}), 128'(2'b10));
    rst = 1'b1;
    #1;
    chk("midrun_reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("midrun_reset_data", 128'({out_quotient, out_remainder}), 128'(0));
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("no_valid_after_reset", 128'(pulses), 128'(0));
    do_div(60'd1000, 60'd8, 7'd96, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = 60'($urandom_range(0, 20000));
      else                           a = 60'({$urandom, $urandom});
      do_div(a, a / 60'd113, 7'(a % 60'd113), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
